// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   - fetch_state_t : fetch FSM states (IDLE, FETCH, CAPTURE, ISSUE)
//   - DATA_W        : instruction word width (matches register_file data width)
//   - ADDR_W        : PC / register_file address width
//   - RESET_PC      : PC value loaded at reset
package fetch_pkg;

  localparam int DATA_W   = 20;
  localparam int ADDR_W   = 4;
  localparam int RESET_PC = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_ISSUE   = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_counter.sv
// Program counter register.
//   clk      : rising-edge clock
//   reset    : asynchronous, active-low; loads RESET_PC
//   load     : load load_val (branch redirect); wins over inc
//   load_val : redirect target
//   inc      : advance by one, modulo 2^ADDR_W
//   pc       : current PC
module pc_counter #(
  parameter int                ADDR_W   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      // Natural wrap at 2^ADDR_W, no overflow indication.
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: reads words from register_file at pc, holds the
// fetched word in an instruction register and offers it to the decoder.
//   clk          : rising-edge clock
//   reset        : asynchronous, active-low
//   mem_addr     : register_file address (always equals pc)
//   mem_rd       : register_file read request
//   mem_data     : register_file read data, valid one cycle after mem_rd
//   instr        : instruction register
//   instr_valid  : instr holds a fetched word
//   instr_ready  : decoder accepts instr this cycle
//   branch_en    : redirect request (single-cycle pulse)
//   branch_addr  : redirect target
//   halt         : level; blocks new fetches while high
//   pc           : current PC
//   fsm_state    : debug view of the fetch FSM state (fetch_state_t encoding)
//
// Handshake: a word transfers to the decoder on every rising clk edge where
// instr_valid && instr_ready are both high; while instr_valid is high and
// instr_ready is low, instr holds steady. instr_valid never drops without a
// transfer except on a branch redirect or reset.
module instr_fetch_unit #(
  parameter int                DATA_W   = fetch_pkg::DATA_W,
  parameter int                ADDR_W   = fetch_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(fetch_pkg::RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        fsm_state
);

  import fetch_pkg::*;

  fetch_state_t state, next_state;
  logic         redirect;
  logic         capture;

  // A redirect is honoured in every state except IDLE and overrides
  // everything else that cycle.
  assign redirect = branch_en && (state != ST_IDLE);
  // A read landing in CAPTURE is dropped if a redirect arrives with it.
  assign capture  = (state == ST_CAPTURE) && !branch_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    mem_rd     = 1'b0;
    case (state)
      ST_IDLE: begin
        next_state = ST_FETCH;
      end
      ST_FETCH: begin
        mem_rd = !halt && !branch_en;
        if (mem_rd) begin
          next_state = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        next_state = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (instr_ready) begin
          next_state = ST_FETCH;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
    if (redirect) begin
      next_state = ST_FETCH;
    end
  end

  // The word is valid exactly while the FSM sits in ISSUE, so the async
  // reset of the state register also clears instr_valid immediately.
  assign instr_valid = (state == ST_ISSUE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr <= '0;
    end else if (capture) begin
      instr <= mem_data;
    end
  end

  pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (redirect),
    .load_val (branch_addr),
    .inc      (capture),
    .pc       (pc)
  );

  assign mem_addr  = pc;
  assign fsm_state = state;

endmodule
